demux1_4_buf: RTL and testbench
===============================

DEMUX1_4_BUF -- requirements
Module: demux1_4_buf

Interface
REQ-001 The parameter DATA_W SHALL default to 32 and SHALL set the payload width.
REQ-002 The parameter CNT_W SHALL default to 16 and SHALL set the width of each per-destination delivery counter.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  SHALL be an asynchronous, active-high reset.
REQ-005 in_data  input  DATA_W  SHALL carry the payload from the source.
REQ-006 in_choice  input  2  SHALL select the destination: 00 to port 0, 01 to port 1, 10 to port 2, 11 to port 3.
REQ-007 in_valid  input  1  SHALL mean the source offers {in_choice, in_data} this cycle.
REQ-008 in_ready  output  1  SHALL mean the block accepts the offer this cycle.
REQ-009 out_data  output  DATA_W  SHALL be the head-entry payload, shared by all four destinations.
REQ-010 out_valid  output  4  SHALL be one-hot, or all zero; bit k SHALL mean the head entry is addressed to destination k.
REQ-011 out_ready  input  4  SHALL carry a bit k for each destination; bit k SHALL mean destination k takes out_data this cycle.
REQ-012 dlv_cnt0..dlv_cnt3  output  CNT_W each  SHALL count the words delivered to each destination.

Function
REQ-013 The block SHALL hold a 2-entry FIFO of {choice[1:0], data}, using rd_ptr, wr_ptr (1 bit each) and count (0..2).
REQ-014 The occupancy states SHALL be EMPTY (count=0), HALF (count=1) and FULL (count=2).
REQ-015 in_ready SHALL equal (count<2) and SHALL be registered-state-only, with no combinational path from out_ready.
REQ-016 A push SHALL occur when in_valid && in_ready, writing entry[wr_ptr] and toggling wr_ptr.
REQ-017 When count>0, out_valid SHALL have exactly the bit of entry[rd_ptr].choice set, and out_data SHALL equal entry[rd_ptr].data.
REQ-018 When count=0, out_valid SHALL be 4'b0000 and out_data SHALL be 0.
REQ-019 A pop SHALL occur when |(out_valid & out_ready); it SHALL toggle rd_ptr and increment dlv_cntK for the popped destination K.
REQ-020 out_ready bits for destinations that are not addressed SHALL be ignored, and they SHALL NOT cause a pop.
REQ-021 Count transitions SHALL be as follows.
- push only: +1
- pop only: -1
- push and pop together: unchanged
- EMPTY to HALF on push; HALF to FULL on push without pop
- FULL to HALF on pop; HALF to EMPTY on pop without push
REQ-022 At FULL with a pop in the same cycle, in_ready SHALL still be 0, so no push occurs that cycle.
REQ-023 In EMPTY, the offered word SHALL NOT bypass to the outputs; the minimum latency from in_valid to out_valid SHALL be 1 cycle.
REQ-024 Delivery SHALL be in strict acceptance order; a stalled head SHALL block later entries, even those for other destinations.
REQ-025 out_data and out_valid SHALL remain stable while the head is not popped.
REQ-026 Each dlv_cntK SHALL wrap from 2^CNT_W-1 to 0 without saturating or flagging.
REQ-027 Pointers SHALL wrap modulo 2.

Reset
REQ-028 While rst=1, asynchronously:
- count, rd_ptr and wr_ptr SHALL be 0
- out_valid SHALL be 0000 and out_data SHALL be 0
- in_ready SHALL be 0
- all dlv_cntK SHALL be 0
REQ-029 in_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-030 Reset asserted mid-operation SHALL discard all buffered entries; no partial delivery SHALL be reported.

Structure
REQ-031 The destination codes (DST0..DST3 = 2'b00..2'b11), FIFO depth 2, and DATA_W/CNT_W defaults SHALL live in the shared CPU constants package.
REQ-032 The design SHALL contain one sub-module, fifo2_ptr, which holds the storage, pointers and count; decode and counters SHALL stay in the top.

Verification
REQ-033 Single word: push 0xDEADBEEF with choice 10 into EMPTY, then hold out_ready=0100 -> out_valid=0100 one cycle later, pop occurs, dlv_cnt2=1, state returns to EMPTY.
REQ-034 Backpressure: push 0x11 (choice 00) and 0x22 (choice 11) with out_ready=0000 -> in_ready falls to 0 at FULL, a third push is refused, 0x11 is held stable on port 0.
REQ-035 Head-of-line blocking: with FULL {port 1: 0xA, port 3: 0xB} and out_ready=1000 for 5 cycles -> no pop and out_valid stays 0010; then out_ready=1010 -> 0xA then 0xB delivered in consecutive cycles.
REQ-036 Streaming: in_valid=1 continuously with choice cycling 00,01,10,11 and out_ready=1111 for 400 cycles -> throughput of one word per cycle, each dlv_cntK=100 at the end, ordering preserved.
REQ-037 Counter wrap: CNT_W=4, deliver 17 words to port 0 -> dlv_cnt0=1.
REQ-038 Reset: assert rst asynchronously at FULL mid-cycle -> out_valid=0000 immediately, all counters 0, and in_ready=1 in the cycle after release.

Source files
------------

// File: rtl/demux1_4_buf_pkg.sv
// Shared constants for the buffered 1-to-4 demultiplexer.
//   dst_e      : destination codes carried with every buffered word
//   occ_e      : occupancy of the 2-entry buffer (encoding equals entry count)
//   FIFO_DEPTH : number of buffered entries
//   DATA_W_DEF / CNT_W_DEF : default payload and delivery-counter widths
package demux1_4_buf_pkg;

  typedef enum logic [1:0] {
    DST0 = 2'b00,
    DST1 = 2'b01,
    DST2 = 2'b10,
    DST3 = 2'b11
  } dst_e;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } occ_e;

  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned CNT_W_DEF  = 16;

endpackage

// File: rtl/demux1_4_buf_if.sv
// Source/sink bundle of the buffered 1-to-4 demultiplexer.
//   in_data/in_choice/in_valid/in_ready : offer from the source
//   out_data/out_valid[3:0]/out_ready[3:0] : shared payload, one-hot valid,
//                                            per-destination ready
// Modports: slave = the demux itself, master = the environment around it.
interface demux1_4_buf_if
  import demux1_4_buf_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
);

  logic [DATA_W-1:0] in_data;
  logic [1:0]        in_choice;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic [3:0]        out_valid;
  logic [3:0]        out_ready;

  modport slave (
    input  in_data, in_choice, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );

  modport master (
    output in_data, in_choice, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

endinterface

// File: rtl/demux1_4_buf_fifo2.sv
// Two-entry FIFO of {choice, data} with 1-bit read/write pointers.
//   push/wr_choice/wr_data : write entry[wr_ptr] (caller guarantees not FULL)
//   pop                    : advance rd_ptr (caller guarantees not EMPTY)
//   rd_choice/rd_data      : head entry
//   occ                    : occupancy EMPTY/HALF/FULL (value = count)
module fifo2_ptr
  import demux1_4_buf_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  dst_e              wr_choice,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              pop,
  output dst_e              rd_choice,
  output logic [DATA_W-1:0] rd_data,
  output occ_e              occ
);

  logic [DATA_W-1:0] data_q   [FIFO_DEPTH];
  dst_e              choice_q [FIFO_DEPTH];
  logic              rd_ptr;
  logic              wr_ptr;
  occ_e              state;
  occ_e              state_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= EMPTY;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        data_q[i]   <= '0;
        choice_q[i] <= DST0;
      end
    end else begin
      state <= state_nx;
      if (push) begin
        data_q[wr_ptr]   <= wr_data;
        choice_q[wr_ptr] <= wr_choice;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      EMPTY: if (push) state_nx = HALF;
      HALF: begin
        if (push && !pop)      state_nx = FULL;
        else if (pop && !push) state_nx = EMPTY;
      end
      FULL:    if (pop) state_nx = HALF;
      default: state_nx = EMPTY;
    endcase
  end

  assign rd_choice = choice_q[rd_ptr];
  assign rd_data   = data_q[rd_ptr];
  assign occ       = state;

endmodule

// File: rtl/demux1_4_buf.sv
// Buffered 1-to-4 demultiplexer with per-destination delivery counters.
//   clk, rst   : clock, asynchronous active-high reset
//   bus        : source offer (in_*) and shared destination side (out_*)
//   dlv_cnt0..3: words delivered to each destination, wrapping
// Words are accepted into a 2-entry FIFO and delivered strictly in order;
// the head blocks later entries until its own destination takes it.
module demux1_4_buf
  import demux1_4_buf_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  demux1_4_buf_if.slave    bus,
  output logic [CNT_W-1:0] dlv_cnt0,
  output logic [CNT_W-1:0] dlv_cnt1,
  output logic [CNT_W-1:0] dlv_cnt2,
  output logic [CNT_W-1:0] dlv_cnt3
);

  logic              push;
  logic              pop;
  dst_e              rd_choice;
  logic [DATA_W-1:0] rd_data;
  occ_e              occ;
  logic [3:0]        valid_oh;
  logic [DATA_W-1:0] data_mux;
  logic [CNT_W-1:0]  cnt [4];

  fifo2_ptr #(
    .DATA_W(DATA_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .wr_choice(dst_e'(bus.in_choice)),
    .wr_data  (bus.in_data),
    .pop      (pop),
    .rd_choice(rd_choice),
    .rd_data  (rd_data),
    .occ      (occ)
  );

  // Depends only on stored occupancy (and reset), never on out_ready, so a
  // FULL buffer refuses the offer even in a cycle where the head pops.
  assign bus.in_ready = ~rst & (occ != FULL);
  assign push         = bus.in_valid & bus.in_ready;

  always_comb begin
    valid_oh = '0;
    data_mux = '0;
    if (occ != EMPTY) begin
      data_mux = rd_data;
      unique case (rd_choice)
        DST0: valid_oh = 4'b0001;
        DST1: valid_oh = 4'b0010;
        DST2: valid_oh = 4'b0100;
        DST3: valid_oh = 4'b1000;
        default: valid_oh = '0;
      endcase
    end
  end

  assign bus.out_valid = valid_oh;
  assign bus.out_data  = data_mux;

  // Ready bits of non-addressed destinations are masked out by valid_oh.
  assign pop = |(valid_oh & bus.out_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < 4; k++) begin
        cnt[k] <= '0;
      end
    end else if (pop) begin
      cnt[rd_choice] <= cnt[rd_choice] + CNT_W'(1);
    end
  end

  assign dlv_cnt0 = cnt[0];
  assign dlv_cnt1 = cnt[1];
  assign dlv_cnt2 = cnt[2];
  assign dlv_cnt3 = cnt[3];

endmodule

// File: tb/tb_demux1_4_buf.sv
module tb_demux1_4_buf;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  demux1_4_buf_if #(.DATA_W(32)) bus ();
  demux1_4_buf_if #(.DATA_W(32)) bus_s ();

  logic [15:0] c0, c1, c2, c3;
  logic [3:0]  s0, s1, s2, s3;

  demux1_4_buf #(.DATA_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave),
    .dlv_cnt0(c0), .dlv_cnt1(c1), .dlv_cnt2(c2), .dlv_cnt3(c3)
  );

  demux1_4_buf #(.DATA_W(32), .CNT_W(4)) dut_small (
    .clk(clk), .rst(rst), .bus(bus_s.slave),
    .dlv_cnt0(s0), .dlv_cnt1(s1), .dlv_cnt2(s2), .dlv_cnt3(s3)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: ordered queue of accepted words, capacity 2.
  typedef struct {
    logic [1:0]  ch;
    logic [31:0] d;
  } ent_t;

  ent_t        mq[$];
  logic [15:0] mcnt [4] = '{default: '0};

  always @(posedge clk or posedge rst) begin : model_upd
    logic m_pop;
    logic m_push;
    logic [1:0] hc;
    if (rst) begin
      mq.delete();
      for (int k = 0; k < 4; k++) mcnt[k] = '0;
    end else begin
      m_pop = 1'b0;
      if (mq.size() > 0) begin
        hc = mq[0].ch;
        m_pop = bus.out_ready[hc];
      end
      m_push = bus.in_valid && (mq.size() < 2);
      if (m_pop) begin
        mcnt[hc] = mcnt[hc] + 16'd1;
        void'(mq.pop_front());
      end
      if (m_push) mq.push_back('{ch: bus.in_choice, d: bus.in_data});
    end
  end

  always @(negedge clk) begin : compare
    logic [3:0]  eov;
    logic [31:0] eod;
    eov = 4'b0000;
    eod = 32'h0;
    if (mq.size() > 0) begin
      eov = 4'b0001 << mq[0].ch;
      eod = mq[0].d;
    end
    chk("in_ready", bus.in_ready, (!rst && mq.size() < 2));
    chk("out_valid", bus.out_valid, eov);
    chk("out_data", bus.out_data, eod);
    chk("dlv_cnt0", c0, mcnt[0]);
    chk("dlv_cnt1", c1, mcnt[1]);
    chk("dlv_cnt2", c2, mcnt[2]);
    chk("dlv_cnt3", c3, mcnt[3]);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic v, input logic [1:0] ch, input logic [31:0] d);
    bus.in_valid  = v;
    bus.in_choice = ch;
    bus.in_data   = d;
  endtask

  initial begin
    offer(1'b0, 2'b00, 32'h0);
    bus.out_ready   = 4'b0000;
    bus_s.in_valid  = 1'b0;
    bus_s.in_choice = 2'b00;
    bus_s.in_data   = 32'h0;
    bus_s.out_ready = 4'b0000;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", bus.in_ready, 1'b0);
    chk("rst_out_valid", bus.out_valid, 4'b0000);
    chk("rst_out_data", bus.out_data, 32'h0);
    chk("rst_cnt0", c0, 16'd0);
    #1 rst = 1'b0;
    #1 chk("in_ready_after_release", bus.in_ready, 1'b1);

    // Single word to port 2, no bypass while EMPTY
    offer(1'b1, 2'b10, 32'hDEADBEEF);
    bus.out_ready = 4'b0100;
    #1 chk("no_bypass", bus.out_valid, 4'b0000);
    step();
    offer(1'b0, 2'b00, 32'h0);
    chk("single_valid", bus.out_valid, 4'b0100);
    chk("single_data", bus.out_data, 32'hDEADBEEF);
    step();
    chk("single_empty", bus.out_valid, 4'b0000);
    chk("single_cnt2", c2, 16'd1);

    // Backpressure
    bus.out_ready = 4'b0000;
    offer(1'b1, 2'b00, 32'h11); step();
    offer(1'b1, 2'b11, 32'h22); step();
    chk("full_in_ready", bus.in_ready, 1'b0);
    offer(1'b1, 2'b01, 32'h33);
    repeat (3) begin
      step();
      chk("bp_hold_data", bus.out_data, 32'h11);
      chk("bp_hold_valid", bus.out_valid, 4'b0001);
    end
    offer(1'b0, 2'b00, 32'h0);
    bus.out_ready = 4'b1111;
    step();
    chk("bp_second", bus.out_data, 32'h22);
    step();
    chk("bp_drained", bus.out_valid, 4'b0000);
    chk("bp_cnt0", c0, 16'd1);
    chk("bp_cnt3", c3, 16'd1);

    // Head-of-line blocking
    bus.out_ready = 4'b0000;
    offer(1'b1, 2'b01, 32'hA); step();
    offer(1'b1, 2'b11, 32'hB); step();
    offer(1'b0, 2'b00, 32'h0);
    bus.out_ready = 4'b1000;
    repeat (5) begin
      step();
      chk("hol_valid", bus.out_valid, 4'b0010);
      chk("hol_data", bus.out_data, 32'hA);
    end
    bus.out_ready = 4'b1010;
    step();
    chk("hol_next_valid", bus.out_valid, 4'b1000);
    chk("hol_next_data", bus.out_data, 32'hB);
    step();
    chk("hol_empty", bus.out_valid, 4'b0000);
    chk("hol_cnt1", c1, 16'd1);
    chk("hol_cnt3", c3, 16'd2);

    // Streaming at one word per cycle
    bus.out_ready = 4'b1111;
    for (int i = 0; i < 400; i++) begin
      offer(1'b1, 2'(i % 4), 32'h1000 + 32'(i));
      step();
      chk("stream_ready", bus.in_ready, 1'b1);
    end
    offer(1'b0, 2'b00, 32'h0);
    step();
    chk("stream_empty", bus.out_valid, 4'b0000);
    chk("stream_cnt0", c0, 16'd101);
    chk("stream_cnt1", c1, 16'd101);
    chk("stream_cnt2", c2, 16'd101);
    chk("stream_cnt3", c3, 16'd102);

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      offer(1'($urandom_range(0, 2) != 0), 2'($urandom), $urandom);
      bus.out_ready = 4'($urandom);
      step();
    end
    offer(1'b0, 2'b00, 32'h0);
    bus.out_ready = 4'b1111;
    repeat (3) step();

    // Counter wrap on a 4-bit instance
    bus_s.in_valid  = 1'b1;
    bus_s.in_choice = 2'b00;
    bus_s.out_ready = 4'b0001;
    for (int i = 0; i < 17; i++) begin
      bus_s.in_data = 32'(i);
      step();
    end
    chk("wrap_cnt0_at16", s0, 4'd0);
    bus_s.in_valid = 1'b0;
    step();
    chk("wrap_cnt0", s0, 4'd1);
    chk("wrap_cnt1", s1, 4'd0);
    chk("wrap_empty", bus_s.out_valid, 4'b0000);

    // Asynchronous reset while FULL
    bus.out_ready = 4'b0000;
    offer(1'b1, 2'b10, 32'h55); step();
    offer(1'b1, 2'b01, 32'h66); step();
    offer(1'b0, 2'b00, 32'h0);
    chk("pre_rst_valid", bus.out_valid, 4'b0100);
    chk("pre_rst_full", bus.in_ready, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", bus.out_valid, 4'b0000);
    chk("arst_out_data", bus.out_data, 32'h0);
    chk("arst_in_ready", bus.in_ready, 1'b0);
    chk("arst_cnt0", c0, 16'd0);
    chk("arst_cnt2", c2, 16'd0);
    chk("arst_cnt3", c3, 16'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    #1 chk("post_rst_ready", bus.in_ready, 1'b1);
    bus.out_ready = 4'b1111;
    step();
    chk("post_rst_no_delivery", bus.out_valid, 4'b0000);
    chk("post_rst_cnt2", c2, 16'd0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
